// File: rtl/ej1_moore_ctrl_if.sv
// -----------------------------------------------------------------------------
// ej1_moore_ctrl_if
//
// Bundle between the exercise test harness (master) and the exercise-1
// sequencing controller (slave).
//
// Signals:
//   inputStart    harness -> ctrl  run request, only looked at while idle
//   inputPattern  harness -> ctrl  N-bit S stimulus, applied LSB first
//   outputBusy    ctrl -> harness  high while initialising / stepping
//   outputDone    ctrl -> harness  one-cycle completion pulse
//   outputCount   ctrl -> harness  number of steps that landed in state 01
//   outputState   ctrl -> harness  machine state {y1,y2}
//   outputZ       ctrl -> harness  Moore output, (state == 01)
// -----------------------------------------------------------------------------
interface ej1_moore_ctrl_if #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
);
    logic          inputStart;
    logic [N-1:0]  inputPattern;
    logic          outputBusy;
    logic          outputDone;
    logic [CW-1:0] outputCount;
    logic [1:0]    outputState;
    logic          outputZ;

    modport master (
        output inputStart,
        output inputPattern,
        input  outputBusy,
        input  outputDone,
        input  outputCount,
        input  outputState,
        input  outputZ
    );

    modport slave (
        input  inputStart,
        input  inputPattern,
        output outputBusy,
        output outputDone,
        output outputCount,
        output outputState,
        output outputZ
    );
endinterface

// File: rtl/ej1_moore_ctrl.sv
// -----------------------------------------------------------------------------
// ej1_moore_ctrl
//
// Sequencing controller for the exercise-1 Moore machine. Owns the 2-bit
// machine state {y1,y2}. On an accepted start it forces the machine to 11
// (I=0) for one cycle, then clocks it through an N-bit serial pattern on S,
// one bit per cycle, counting the steps that land in state 01.
//
// Ports:
//   inputClock  rising-edge clock
//   inputReset  synchronous, active-high reset
//   bus         ej1_moore_ctrl_if.slave (start/pattern in, busy/done/
//               count/state/Z out)
//
// Timeline for a start accepted at edge t:
//   cycle t+1          INIT  (busy)
//   cycles t+2..t+N+1  RUN   (busy, one pattern bit per cycle)
//   cycle t+N+2        DONE  (done pulse, busy low, results final)
//   cycle t+N+3        IDLE
// -----------------------------------------------------------------------------
module ej1_moore_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic            inputClock,
    input  logic            inputReset,
    ej1_moore_ctrl_if.slave bus
);

    // Step index only needs to reach N-1.
    localparam int            IW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    // Controller states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_INIT = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Machine states of interest.
    localparam logic [1:0] M_FORCED = 2'b11;
    localparam logic [1:0] M_DETECT = 2'b01;

    // Exercise-1 next-state equations:
    //   Y1 = ~I | (~S & (~y1 | y2))
    //   Y2 = ~I | (~y2 & y1 & ~S)
    function automatic logic [1:0] next_machine(
        input logic [1:0] y,
        input logic       i_in,
        input logic       s_in
    );
        logic y1;
        logic y2;
        logic n1;
        logic n2;
        y1 = y[1];
        y2 = y[0];
        n1 = ~i_in | (~s_in & (~y1 | y2));
        n2 = ~i_in | (~y2 & y1 & ~s_in);
        return {n1, n2};
    endfunction

    logic [1:0]    ctrl_q,   ctrl_d;
    logic [1:0]    mstate_q, mstate_d;
    logic [N-1:0]  shift_q,  shift_d;
    logic [IW-1:0] idx_q,    idx_d;
    logic [CW-1:0] count_q,  count_d;
    logic          z_q,      z_d;

    // Machine state that the current RUN step would produce.
    logic [1:0]    step_state;

    always_comb begin
        ctrl_d     = ctrl_q;
        mstate_d   = mstate_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        count_d    = count_q;
        step_state = next_machine(mstate_q, 1'b1, shift_q[0]);

        case (ctrl_q)
            ST_IDLE: begin
                if (bus.inputStart) begin
                    shift_d = bus.inputPattern;
                    idx_d   = '0;
                    count_d = '0;
                    ctrl_d  = ST_INIT;
                end
            end

            ST_INIT: begin
                // I=0 drives both equations to 1, forcing 11.
                mstate_d = next_machine(mstate_q, 1'b0, 1'b0);
                ctrl_d   = ST_RUN;
            end

            ST_RUN: begin
                mstate_d = step_state;
                shift_d  = shift_q >> 1;
                if (step_state == M_DETECT) begin
                    count_d = count_q + CW'(1);
                end
                if (idx_q == LAST_IDX) begin
                    ctrl_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end

            ST_DONE: begin
                // Start is deliberately not sampled here.
                ctrl_d = ST_IDLE;
            end

            default: begin
                ctrl_d = ST_IDLE;
            end
        endcase

        // Z is registered alongside the state so it is a pure state decode.
        z_d = (mstate_d == M_DETECT);
    end

    always_ff @(posedge inputClock) begin
        if (inputReset) begin
            ctrl_q   <= ST_IDLE;
            mstate_q <= M_FORCED;
            shift_q  <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            z_q      <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            mstate_q <= mstate_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            z_q      <= z_d;
        end
    end

    assign bus.outputBusy  = (ctrl_q == ST_INIT) || (ctrl_q == ST_RUN);
    assign bus.outputDone  = (ctrl_q == ST_DONE);
    assign bus.outputCount = count_q;
    assign bus.outputState = mstate_q;
    assign bus.outputZ     = z_q;

endmodule

// File: tb/tb_ej1_moore_ctrl.sv
// -----------------------------------------------------------------------------
// tb_ej1_moore_ctrl
//
// Directed bench for ej1_moore_ctrl (N=8). Inputs are driven and outputs
// sampled 1 time unit after each rising edge. Expected machine-state
// sequences and counts are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_ej1_moore_ctrl;

    localparam int N  = 8;
    localparam int CW = $clog2(N + 1);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ej1_moore_ctrl_if #(.N(N), .CW(CW)) bus ();

    ej1_moore_ctrl #(.N(N), .CW(CW)) dut (
        .inputClock (clk),
        .inputReset (rst),
        .bus        (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    // exp_st[0] is the state in the first RUN cycle, exp_st[N] the final one.
    logic [1:0] exp_st [0:N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; returns in the IDLE cycle after DONE.
    task automatic run_pattern(input logic [N-1:0] pat, input logic [CW-1:0] exp_cnt,
                               input bit hold, input bit poke);
        bus.inputStart   = 1'b1;
        bus.inputPattern = pat;
        step();  // INIT
        chk("init_busy", 32'(bus.outputBusy), 1);
        chk("init_done", 32'(bus.outputDone), 0);
        chk("init_cnt_clr", 32'(bus.outputCount), 0);
        if (!hold) bus.inputStart = 1'b0;
        bus.inputPattern = ~pat;  // must not affect the run
        for (int k = 0; k < N; k++) begin
            step();  // RUN cycle k
            if (poke) bus.inputStart = (k == 2);
            chk($sformatf("run%0d_state", k), 32'(bus.outputState), 32'(exp_st[k]));
            chk($sformatf("run%0d_z", k), 32'(bus.outputZ), 32'(exp_st[k] == 2'b01));
            chk($sformatf("run%0d_busy", k), 32'(bus.outputBusy), 1);
            chk($sformatf("run%0d_done", k), 32'(bus.outputDone), 0);
        end
        step();  // DONE
        if (poke) bus.inputStart = 1'b1;
        chk("done_pulse", 32'(bus.outputDone), 1);
        chk("done_busy", 32'(bus.outputBusy), 0);
        chk("done_state", 32'(bus.outputState), 32'(exp_st[N]));
        chk("done_z", 32'(bus.outputZ), 32'(exp_st[N] == 2'b01));
        chk("done_count", 32'(bus.outputCount), 32'(exp_cnt));
        step();  // IDLE
        if (poke) bus.inputStart = 1'b0;
        chk("idle_done", 32'(bus.outputDone), 0);
        chk("idle_busy", 32'(bus.outputBusy), 0);
        chk("idle_state", 32'(bus.outputState), 32'(exp_st[N]));
        chk("idle_count", 32'(bus.outputCount), 32'(exp_cnt));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_seen;

        rst              = 1'b1;
        bus.inputStart   = 1'b0;
        bus.inputPattern = '0;
        step();
        step();
        chk("rst_busy", 32'(bus.outputBusy), 0);
        chk("rst_done", 32'(bus.outputDone), 0);
        chk("rst_count", 32'(bus.outputCount), 0);
        chk("rst_state", 32'(bus.outputState), 32'h3);
        chk("rst_z", 32'(bus.outputZ), 0);
        rst = 1'b0;
        step();
        chk("idle_hold_state", 32'(bus.outputState), 32'h3);

        // All-zero pattern: 11 then alternating 10/01.
        exp_st = '{2'b11, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        run_pattern(8'h00, CW'(4), 1'b0, 1'b0);

        // All-one pattern: every step goes to 00.
        exp_st = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
        run_pattern(8'hFF, CW'(0), 1'b0, 1'b0);

        // S = 0,0,1,0,0,0,0,0 with start held high into the next run.
        exp_st = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        run_pattern(8'h04, CW'(3), 1'b1, 1'b0);

        // Back-to-back run; its INIT cycle shows the count cleared from 3.
        exp_st = '{2'b11, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
        run_pattern(8'h55, CW'(0), 1'b0, 1'b0);

        // Start pulses during RUN and DONE are ignored.
        exp_st = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        run_pattern(8'h04, CW'(3), 1'b0, 1'b1);
        done_seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (bus.outputDone || bus.outputBusy) done_seen++;
        end
        chk("poke_no_extra_run", 32'(done_seen), 0);

        // Reset in the 4th RUN cycle of an all-zero run.
        bus.inputStart   = 1'b1;
        bus.inputPattern = 8'h00;
        step();  // INIT
        bus.inputStart = 1'b0;
        step();
        step();
        step();
        step();  // 4th RUN cycle
        chk("abort_pre_state", 32'(bus.outputState), 32'h2);
        chk("abort_pre_count", 32'(bus.outputCount), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", 32'(bus.outputBusy), 0);
        chk("abort_done", 32'(bus.outputDone), 0);
        chk("abort_state", 32'(bus.outputState), 32'h3);
        chk("abort_count", 32'(bus.outputCount), 0);
        chk("abort_z", 32'(bus.outputZ), 0);
        done_seen = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (bus.outputDone) done_seen++;
        end
        chk("abort_no_done", 32'(done_seen), 0);
        chk("abort_idle_busy", 32'(bus.outputBusy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
